// File: rtl/uart_trace_tx_pkg.sv
// Shared definitions for the UART trace transmitter: FSM encoding, record layout
// and the record-to-byte mapping.
package uart_trace_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [3:0] TRACE_SYNC  = 4'hA;
  localparam int         TRACE_REC_W = 20;
  localparam int         TRACE_BYTES = 3;

  // Record layout is {flags[3:0], pc[7:0], result[7:0]}; byte 0 carries the sync nibble.
  function automatic logic [7:0] trace_byte(input logic [TRACE_REC_W-1:0] rec,
                                            input logic [1:0]             idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {TRACE_SYNC, rec[19:16]};
      2'd1:    b = rec[15:8];
      default: b = rec[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO for trace records. A push while full is still
// accepted when a pop happens in the same cycle.
module trace_fifo
  import uart_trace_tx_pkg::*;
#(
  parameter int W     = TRACE_REC_W,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_trace_tx.sv
// Trace stage: captures {flags, PC, result} per executed instruction, buffers the
// records and streams each as three 8N1 bytes on a registered TXD line.
module uart_trace_tx
  import uart_trace_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 43,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic       i_Valid,
  input  logic [7:0] i_PC,
  input  logic [7:0] i_Result,
  input  logic [3:0] i_Flags,
  output logic       o_TXD,
  output logic       o_Busy,
  output logic       o_Overflow,
  output logic [1:0] o_State
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        LAST_IDX  = 2'(TRACE_BYTES - 1);

  tx_state_t               state, state_nxt;
  logic [BAUD_W-1:0]       baud_cnt, baud_nxt;
  logic [2:0]              bit_cnt, bit_nxt;
  logic [1:0]              byte_idx, idx_nxt;
  logic [TRACE_REC_W-1:0]  hold_rec;
  logic                    load_hold;
  logic                    tx_bit;
  logic                    baud_done;
  logic [7:0]              cur_byte;

  logic                    fifo_pop;
  logic [TRACE_REC_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;

  trace_fifo #(
    .W     (TRACE_REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_CLK),
    .rst   (i_RESET),
    .push  (i_Valid),
    .pop   (fifo_pop),
    .wdata ({i_Flags, i_PC, i_Result}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign cur_byte  = trace_byte(hold_rec, byte_idx);
  assign o_State   = state;

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    idx_nxt   = byte_idx;
    load_hold = 1'b0;
    tx_bit    = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_hold = 1'b1;
          idx_nxt   = 2'd0;
          baud_nxt  = '0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx_bit = 1'b0;
        if (baud_done) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = ST_DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        tx_bit = cur_byte[bit_cnt];
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) state_nxt = ST_STOP;
          else                 bit_nxt   = bit_cnt + 1'b1;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (byte_idx == LAST_IDX) begin
            state_nxt = ST_IDLE;
          end else begin
            idx_nxt   = byte_idx + 1'b1;
            state_nxt = ST_START;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      byte_idx <= idx_nxt;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      hold_rec <= '0;
    end else if (load_hold) begin
      hold_rec <= fifo_rdata;
    end
  end

  // TXD follows the state one cycle later, so the line never glitches on decode.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      o_TXD      <= 1'b1;
      o_Busy     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      o_TXD  <= tx_bit;
      o_Busy <= (state != ST_IDLE) || (fifo_count != '0);
      if (i_Valid && fifo_full && !fifo_pop) begin
        o_Overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_trace_tx.sv
// Bench for uart_trace_tx: record-level timing model, per-cycle output compare,
// UART byte decoder with expected-byte scoreboard, and directed scenarios.
module tb_uart_trace_tx;

  localparam int CPB     = 4;
  localparam int DEPTH   = 4;
  localparam int REC_CYC = 30 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] pc;
  logic [7:0] res;
  logic [3:0] flags;
  logic       txd;
  logic       busy;
  logic       ovf;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  uart_trace_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_CLK      (clk),
    .i_RESET    (rst),
    .i_Valid    (valid),
    .i_PC       (pc),
    .i_Result   (res),
    .i_Flags    (flags),
    .o_TXD      (txd),
    .o_Busy     (busy),
    .o_Overflow (ovf),
    .o_State    (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [19:0] rec_q[$];
  logic        wave_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_log[$];
  int          cyc      = 0;
  int          free_at  = 0;
  logic        exp_txd  = 1'b1;
  logic        exp_busy = 1'b0;
  logic        exp_ovf  = 1'b0;
  bit          model_ok = 1'b0;

  function automatic logic [7:0] rec_byte(input logic [19:0] r, input int b);
    if (b == 0) return {4'hA, r[19:16]};
    if (b == 1) return r[15:8];
    return r[7:0];
  endfunction

  task automatic add_wave(input logic [19:0] r);
    logic [7:0] v;
    for (int b = 0; b < 3; b++) begin
      v = rec_byte(r, b);
      for (int c = 0; c < CPB; c++) wave_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < CPB; c++) wave_q.push_back(v[i]);
      for (int c = 0; c < CPB; c++) wave_q.push_back(1'b1);
    end
  endtask

  // A record leaves the FIFO at the first edge the transmitter is free; its frame
  // appears on the line from the following edge and the next pop may come one
  // cycle after the frame ends.
  always @(posedge clk) begin : model
    int         cnt_before;
    bit         pop;
    logic [19:0] r;
    cyc++;
    if (rst) begin
      rec_q.delete();
      wave_q.delete();
      exp_q.delete();
      free_at  = cyc + 1;
      exp_txd  = 1'b1;
      exp_busy = 1'b0;
      exp_ovf  = 1'b0;
      model_ok = 1'b1;
    end else begin
      cnt_before = rec_q.size();
      exp_busy   = (cnt_before != 0) || (cyc < free_at);
      exp_txd    = (wave_q.size() != 0) ? wave_q.pop_front() : 1'b1;
      pop        = (cnt_before > 0) && (cyc >= free_at);
      if (pop) begin
        r = rec_q.pop_front();
        add_wave(r);
        free_at = cyc + REC_CYC + 1;
      end
      if (valid) begin
        if (cnt_before < DEPTH || pop) begin
          rec_q.push_back({flags, pc, res});
          for (int b = 0; b < 3; b++) exp_q.push_back(rec_byte({flags, pc, res}, b));
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- compare + UART decoder ----------------
  int         rx_pos = -1;
  logic [7:0] rx_byte;

  always @(posedge clk) begin : compare
    int k;
    #1;
    if (model_ok) begin
      check("txd", txd, exp_txd);
      check("busy", busy, exp_busy);
      check("overflow", ovf, exp_ovf);
      if (rst) begin
        rx_pos = -1;
      end else if (rx_pos < 0) begin
        if (txd == 1'b0) rx_pos = 0;
      end else begin
        rx_pos++;
        if ((rx_pos % CPB) == CPB / 2) begin
          k = rx_pos / CPB;
          if (k >= 1 && k <= 8) rx_byte[k-1] = txd;
          if (k == 9) begin
            check("rx_stop", txd, 1'b1);
            rx_log.push_back(rx_byte);
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL rx_extra_byte: got %02h expected none", rx_byte);
            end else begin
              check("rx_byte", rx_byte, exp_q.pop_front());
            end
            rx_pos = -1;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_rec(input logic [3:0] f, input logic [7:0] p, input logic [7:0] r);
    valid = 1'b1;
    flags = f;
    pc    = p;
    res   = r;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] f0;
    logic [9:0] f1;
    logic       eb;
    rst = 1'b1; valid = 1'b0; pc = '0; res = '0; flags = '0;

    // 1: reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_txd", txd, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ovf", ovf, 1'b0);

    // 2: single record, latency and busy fall
    rx_log.delete();
    set_rec(4'b1000, 8'h12, 8'h34);
    @(posedge clk); #1;
    @(negedge clk); valid = 1'b0;
    @(posedge clk); #1;
    check("t2_txd_n1", txd, 1'b1);
    @(posedge clk); #1;
    check("t2_start_n2", txd, 1'b0);
    check("t2_busy_n2", busy, 1'b1);
    repeat (119) @(posedge clk); #1;
    check("t2_busy_n121", busy, 1'b1);
    @(posedge clk); #1;
    check("t2_busy_n122", busy, 1'b0);
    @(negedge clk);
    check("t2_nbytes", rx_log.size(), 3);
    if (rx_log.size() == 3) begin
      check("t2_byte0", rx_log[0], 8'hA8);
      check("t2_byte1", rx_log[1], 8'h12);
      check("t2_byte2", rx_log[2], 8'h34);
    end
    repeat (5) @(negedge clk);

    // 3: bit timing of byte0 (0xA0) and byte1 (0x55), back to back
    rx_log.delete();
    set_rec(4'b0000, 8'h55, 8'h55);
    @(posedge clk); #1;
    @(negedge clk); valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    f0 = {1'b1, 8'hA0, 1'b0};
    f1 = {1'b1, 8'h55, 1'b0};
    for (int s = 0; s < 20; s++) begin
      for (int c = 0; c < CPB; c++) begin
        eb = (s < 10) ? f0[s] : f1[s-10];
        check($sformatf("t3_slot%0d", s), txd, eb);
        @(posedge clk); #1;
      end
    end
    repeat (50) @(negedge clk);
    check("t3_nbytes", rx_log.size(), 3);
    if (rx_log.size() == 3) check("t3_byte2", rx_log[2], 8'h55);

    // 4: six back-to-back records from empty, sixth dropped
    rx_log.delete();
    for (int i = 0; i < 6; i++) begin
      set_rec(4'(i), 8'h20 + 8'(i), 8'h40 + 8'(i));
      @(posedge clk); #1;
      if (i == 4) check("t4_ovf_before", ovf, 1'b0);
      if (i == 5) check("t4_ovf_set", ovf, 1'b1);
      @(negedge clk);
    end
    valid = 1'b0;
    repeat (5 * (REC_CYC + 1) + 10) @(negedge clk);
    check("t4_ovf_sticky", ovf, 1'b1);
    check("t4_busy_idle", busy, 1'b0);
    check("t4_nbytes", rx_log.size(), 15);
    if (rx_log.size() == 15) begin
      check("t4_rec0_b0", rx_log[0], 8'hA0);
      check("t4_rec0_b1", rx_log[1], 8'h20);
      check("t4_rec4_b0", rx_log[12], 8'hA4);
      check("t4_rec4_b1", rx_log[13], 8'h24);
      check("t4_rec4_b2", rx_log[14], 8'h44);
    end

    // 5: FIFO full, push in the same cycle as the IDLE pop
    do_reset(2);
    rx_log.delete();
    for (int i = 0; i < 5; i++) begin
      set_rec(4'(i), 8'h60 + 8'(i), 8'h80 + 8'(i));
      @(negedge clk);
    end
    valid = 1'b0;
    repeat (117) @(negedge clk);
    set_rec(4'hF, 8'hEE, 8'hDD);
    @(posedge clk); #1;
    check("t5_ovf_clear", ovf, 1'b0);
    @(negedge clk); valid = 1'b0;
    repeat (5 * (REC_CYC + 1) + 10) @(negedge clk);
    check("t5_ovf_final", ovf, 1'b0);
    check("t5_nbytes", rx_log.size(), 18);
    if (rx_log.size() == 18) begin
      check("t5_last_b0", rx_log[15], 8'hAF);
      check("t5_last_b1", rx_log[16], 8'hEE);
      check("t5_last_b2", rx_log[17], 8'hDD);
    end

    // 6: reset during byte1 data bits
    rx_log.delete();
    set_rec(4'b0011, 8'hC3, 8'h3C);
    @(negedge clk); valid = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_txd_after_rst", txd, 1'b1);
    check("t6_busy_after_rst", busy, 1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_fifo_empty", busy, 1'b0);
    check("t6_aborted_bytes", rx_log.size(), 1);
    rx_log.delete();
    set_rec(4'b0110, 8'h77, 8'h99);
    @(negedge clk); valid = 1'b0;
    repeat (REC_CYC + 10) @(negedge clk);
    check("t6_nbytes", rx_log.size(), 3);
    if (rx_log.size() == 3) begin
      check("t6_byte0", rx_log[0], 8'hA6);
      check("t6_byte1", rx_log[1], 8'h77);
      check("t6_byte2", rx_log[2], 8'h99);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
